// File: rtl/gelato_fetch_scheduler_pkg.sv
// Shared types for the gelato fetch front end.
// Warp slot, PC and split-table bundles.
package gelato_types;

  localparam int NUM_WARPS = 4;
  localparam int WARP_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int ADDR_W    = 32;
  localparam int SPLIT_W   = 4;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [WARP_W-1:0]  warp_num_t;
  typedef logic [SPLIT_W-1:0] split_num_t;

  typedef struct packed {
    addr_t      pc;
    warp_num_t  warp_num;
    split_num_t split_table_num;
  } pc_info_t;

  typedef struct packed {
    warp_num_t  warp_num;
    addr_t      pc;
    split_num_t split_table_num;
    logic       exit;
  } pc_update_t;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Round-robin arbiter: search starts one past last_grant.
// Purely combinational.
module gelato_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] idx;

  // farthest offset first so the nearest requester wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = last_grant + IW'(k);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Warp fetch scheduler: per-warp PC state and
// registered round-robin offer to inst fetch.
module gelato_fetch_scheduler
  import gelato_types::*;
#(
  parameter int NUM_WARPS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 launch_valid,
  input  warp_num_t            launch_warp_num,
  input  addr_t                launch_pc,
  input  logic                 update_valid,
  input  pc_update_t           update,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output pc_info_t             dout,
  output logic [NUM_WARPS-1:0] active_mask
);

  localparam int WW = $bits(warp_num_t);

  logic [NUM_WARPS-1:0] active_q, active_d;
  logic [NUM_WARPS-1:0] pending_q, pending_d;
  addr_t                pc_q [NUM_WARPS];
  addr_t                pc_d [NUM_WARPS];
  split_num_t           split_q [NUM_WARPS];
  split_num_t           split_d [NUM_WARPS];
  warp_num_t            last_grant_q, last_grant_d;
  logic                 dout_valid_q, dout_valid_d;
  pc_info_t             dout_q, dout_d;

  logic                 hs;
  logic [NUM_WARPS-1:0] hs_onehot;
  logic [NUM_WARPS-1:0] arb_req;
  warp_num_t            arb_last;
  logic [NUM_WARPS-1:0] arb_grant;
  warp_num_t            arb_idx;
  logic                 arb_any;
  logic                 upd_ok;
  logic                 launch_ok;

  assign hs        = dout_valid_q & dout_ready;
  assign hs_onehot = hs ? (NUM_WARPS'(1) << dout_q.warp_num) : '0;
  assign arb_req   = active_q & ~pending_q & ~hs_onehot;
  assign arb_last  = hs ? dout_q.warp_num : last_grant_q;
  assign upd_ok    = update_valid & pending_q[update.warp_num];
  assign launch_ok = launch_valid & ~active_q[launch_warp_num]
                   & ~(update_valid
                       & (update.warp_num == launch_warp_num));

  gelato_rr_arbiter #(
    .N  (NUM_WARPS),
    .IW (WW)
  ) u_arb (
    .req        (arb_req),
    .last_grant (arb_last),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  // next state: handshake, write-back, launch, offer
  always_comb begin
    active_d     = active_q;
    pending_d    = pending_q;
    pc_d         = pc_q;
    split_d      = split_q;
    last_grant_d = last_grant_q;
    dout_valid_d = dout_valid_q;
    dout_d       = dout_q;
    if (hs) begin
      pending_d[dout_q.warp_num] = 1'b1;
      last_grant_d               = dout_q.warp_num;
    end
    if (upd_ok) begin
      pc_d[update.warp_num]      = update.pc;
      split_d[update.warp_num]   = update.split_table_num;
      pending_d[update.warp_num] = 1'b0;
      if (update.exit) begin
        active_d[update.warp_num] = 1'b0;
      end
    end
    if (launch_ok) begin
      active_d[launch_warp_num]  = 1'b1;
      pending_d[launch_warp_num] = 1'b0;
      pc_d[launch_warp_num]      = launch_pc;
      split_d[launch_warp_num]   = '0;
    end
    if (!dout_valid_q || dout_ready) begin
      dout_valid_d = arb_any;
      dout_d       = '0;
      if (arb_any) begin
        dout_d.warp_num = arb_idx;
      end
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (arb_grant[i]) begin
          dout_d.pc              = pc_q[i];
          dout_d.split_table_num = split_q[i];
        end
      end
    end
  end

  // state registers, frozen while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q     <= '0;
      pending_q    <= '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        pc_q[i]    <= '0;
        split_q[i] <= '0;
      end
      last_grant_q <= warp_num_t'(NUM_WARPS - 1);
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else if (rdy) begin
      active_q     <= active_d;
      pending_q    <= pending_d;
      pc_q         <= pc_d;
      split_q      <= split_d;
      last_grant_q <= last_grant_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
    end
  end

  assign dout_valid  = dout_valid_q;
  assign dout        = dout_q;
  assign active_mask = active_q;

  a_upd_pending : assert property (
    @(posedge clk) disable iff (rst)
    (rdy && update_valid) |-> pending_q[update.warp_num]);

  a_launch_idle : assert property (
    @(posedge clk) disable iff (rst)
    (rdy && launch_valid
     && !(update_valid && update.warp_num == launch_warp_num))
    |-> !active_q[launch_warp_num]);

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Bench for gelato_fetch_scheduler: directed
// scenarios plus random traffic vs a warp model.
module tb_gelato_fetch_scheduler;
  import gelato_types::*;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic       launch_valid;
  warp_num_t  launch_warp_num;
  addr_t      launch_pc;
  logic       update_valid;
  pc_update_t update;
  logic       dout_valid;
  logic       dout_ready;
  pc_info_t   dout;
  logic [N-1:0] active_mask;

  int checks;
  int failures;

  gelato_fetch_scheduler #(.NUM_WARPS(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .launch_valid    (launch_valid),
    .launch_warp_num (launch_warp_num),
    .launch_pc       (launch_pc),
    .update_valid    (update_valid),
    .update          (update),
    .dout_valid      (dout_valid),
    .dout_ready      (dout_ready),
    .dout            (dout),
    .active_mask     (active_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit         m_act [N];
  bit         m_pend [N];
  addr_t      m_pc [N];
  split_num_t m_sp [N];
  int         m_last;
  bit         m_dv;
  pc_info_t   m_dout;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] m_mask();
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = m_act[i];
    return m;
  endfunction

  task automatic model_calc();
    bit       hs;
    int       srch;
    int       pick;
    int       uw;
    int       lw;
    bit       op [N];
    bit       oa [N];
    pc_info_t nd;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0; m_pend[i] = 0; m_pc[i] = '0; m_sp[i] = '0;
      end
      m_last = N - 1;
      m_dv   = 0;
      m_dout = '0;
      return;
    end
    if (!rdy) return;
    op   = m_pend;
    oa   = m_act;
    hs   = m_dv && dout_ready;
    srch = hs ? int'(m_dout.warp_num) : m_last;
    pick = -1;
    nd   = '0;
    for (int k = 1; k <= N; k++) begin
      int w;
      w = (srch + k) % N;
      if (pick < 0 && oa[w] && !op[w]
          && !(hs && w == int'(m_dout.warp_num)))
        pick = w;
    end
    if (pick >= 0) begin
      nd.pc              = m_pc[pick];
      nd.warp_num        = warp_num_t'(pick);
      nd.split_table_num = m_sp[pick];
    end
    if (hs) begin
      m_pend[m_dout.warp_num] = 1;
      m_last = int'(m_dout.warp_num);
    end
    uw = int'(update.warp_num);
    lw = int'(launch_warp_num);
    if (update_valid && op[uw]) begin
      m_pc[uw]   = update.pc;
      m_sp[uw]   = update.split_table_num;
      m_pend[uw] = 0;
      if (update.exit) m_act[uw] = 0;
    end
    if (launch_valid && !oa[lw] && !(update_valid && uw == lw)) begin
      m_act[lw]  = 1;
      m_pend[lw] = 0;
      m_pc[lw]   = launch_pc;
      m_sp[lw]   = '0;
    end
    if (!m_dv || dout_ready) begin
      m_dv   = (pick >= 0);
      m_dout = nd;
    end
  endtask

  task automatic step();
    model_calc();
    @(posedge clk);
    #1;
    chk("dv", 64'(dout_valid), 64'(m_dv));
    if (m_dv) chk("dout", 64'(dout), 64'(m_dout));
    chk("mask", 64'(active_mask), 64'(m_mask()));
  endtask

  task automatic idle();
    rdy             = 1'b1;
    launch_valid    = 1'b0;
    launch_warp_num = '0;
    launch_pc       = '0;
    update_valid    = 1'b0;
    update          = '0;
    dout_ready      = 1'b0;
  endtask

  task automatic do_launch(int w, addr_t pc);
    launch_valid    = 1'b1;
    launch_warp_num = warp_num_t'(w);
    launch_pc       = pc;
  endtask

  task automatic do_update(int w, addr_t pc, int sp, bit ex);
    update_valid           = 1'b1;
    update.warp_num        = warp_num_t'(w);
    update.pc              = pc;
    update.split_table_num = split_num_t'(sp);
    update.exit            = ex;
  endtask

  int gq[$];

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b1;
    step();
    step();
    chk("rst_dv", 64'(dout_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_mask", 64'(active_mask), 64'd0);
    rst = 1'b0;
    step();

    do_launch(2, 32'h100);
    step();
    launch_valid = 1'b0;
    chk("l2_early", 64'(dout_valid), 64'd0);
    step();
    chk("l2_dv", 64'(dout_valid), 64'd1);
    chk("l2_dout", 64'(dout), 64'({32'h100, 2'd2, 4'd0}));
    dout_ready = 1'b1;
    step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_launch(i, 32'h1000 + 32'(i * 16));
      step();
      if (dout_valid) gq.push_back(int'(dout.warp_num));
    end
    launch_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dout_valid) gq.push_back(int'(dout.warp_num));
    end
    chk("rr_cnt", 64'(gq.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("rr_gnt", 64'(i < gq.size() ? gq[i] : -1), 64'(i));
    chk("rr_idle", 64'(dout_valid), 64'd0);

    dout_ready = 1'b0;
    do_update(1, 32'h204, 3, 1'b0);
    step();
    update_valid = 1'b0;
    step();
    chk("upd_dout", 64'(dout), 64'({32'h204, 2'd1, 4'd3}));
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    do_update(1, 32'h208, 0, 1'b1);
    step();
    update_valid = 1'b0;
    chk("exit_mask", 64'(active_mask), 64'b1101);
    dout_ready = 1'b1;
    repeat (4) begin
      step();
      chk("exit_none", 64'(dout_valid), 64'd0);
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    dout_ready = 1'b0;
    do_launch(1, 32'h40);
    step();
    launch_valid = 1'b0;
    step();
    do_launch(3, 32'h80);
    for (int i = 0; i < 5; i++) begin
      step();
      launch_valid = 1'b0;
      chk("hold_dv", 64'(dout_valid), 64'd1);
      chk("hold_w", 64'(dout.warp_num), 64'd1);
    end
    dout_ready = 1'b1;
    step();
    chk("next_dv", 64'(dout_valid), 64'd1);
    chk("next_w", 64'(dout.warp_num), 64'd3);

    rdy = 1'b0;
    do_update(1, 32'h300, 5, 1'b0);
    step();
    chk("stall_dv", 64'(dout_valid), 64'd1);
    chk("stall_w", 64'(dout.warp_num), 64'd3);
    chk("stall_mask", 64'(active_mask), 64'b1010);
    rdy = 1'b1;
    step();
    update_valid = 1'b0;
    dout_ready   = 1'b0;
    chk("go_dv", 64'(dout_valid), 64'd0);
    step();
    chk("go_dout", 64'(dout), 64'({32'h300, 2'd1, 4'd5}));

    rst = 1'b1;
    step();
    chk("mid_rst_dv", 64'(dout_valid), 64'd0);
    chk("mid_rst_mask", 64'(active_mask), 64'd0);
    rst = 1'b0;
    dout_ready = 1'b1;
    repeat (3) begin
      step();
      chk("post_rst_dv", 64'(dout_valid), 64'd0);
    end

    for (int c = 0; c < 3000; c++) begin
      int w;
      int u;
      rst        = ($urandom_range(0, 199) == 0);
      rdy        = ($urandom_range(0, 9) != 0);
      dout_ready = ($urandom_range(0, 2) != 0);
      w = int'($urandom_range(0, N - 1));
      u = int'($urandom_range(0, N - 1));
      launch_valid    = !m_act[w] && ($urandom_range(0, 3) == 0);
      launch_warp_num = warp_num_t'(w);
      launch_pc       = addr_t'($urandom) & ~addr_t'(3);
      update_valid    = m_pend[u] && ($urandom_range(0, 1) == 1);
      update.warp_num = warp_num_t'(u);
      update.pc       = addr_t'($urandom);
      update.split_table_num = split_num_t'($urandom);
      update.exit     = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gelato_fetch_scheduler.md
GELATO_FETCH_SCHEDULER -- requirements
Module: gelato_fetch_scheduler

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warp slots (power of two, 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock for the block.
REQ-003 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-004 SHALL have port rdy, input, 1, global stall; low means all state holds.
REQ-005 SHALL have port launch_valid, input, 1, start a warp.
REQ-006 SHALL have port launch_warp_num, input, warp_num_t, warp slot to start.
REQ-007 SHALL have port launch_pc, input, addr_t, entry PC.
REQ-008 SHALL have port update_valid, input, 1, next-PC write-back from downstream.
REQ-009 SHALL have port update, input, pc_update_t, carries {warp_num, pc, split_table_num, exit}.
REQ-010 SHALL have port dout_valid, output, 1, pc_info_t offered to gelato_inst_fetch.
REQ-011 SHALL have port dout_ready, input, 1, fetch stage accepts.
REQ-012 SHALL have port dout, output, pc_info_t, {pc, warp_num, split_table_num}.
REQ-013 SHALL have port active_mask, output, NUM_WARPS, per-warp active bits, for the dispatcher.

Function
REQ-014 SHALL keep per warp: active, pending, pc, split_table_num.
REQ-015 SHALL treat a warp as eligible when active=1 and pending=0.
REQ-016 SHALL select among eligible warps round-robin, searching from (last_grant+1) mod NUM_WARPS.
REQ-017 SHALL register the selection: eligible warp at edge N gives dout_valid=1 after edge N+1.
REQ-018 SHALL, while dout_valid=1 and dout_ready=0, hold dout stable, with no re-arbitration.
REQ-019 SHALL, on handshake (dout_valid & dout_ready & rdy), set pending for dout.warp_num and update last_grant.
REQ-020 SHALL exclude the granted warp from the same-cycle arbitration, so a different eligible warp gets dout_valid=1 on the next cycle (back-to-back issue).
REQ-021 SHALL, on update_valid to a pending warp, write pc and split_table_num and clear pending; exit=1 also clears active.
REQ-022 SHALL ignore update_valid to a non-pending warp and flag it with a simulation assertion.
REQ-023 SHALL, on launch_valid to an inactive warp, set active=1, pending=0, pc=launch_pc and split_table_num=0.
REQ-024 SHALL ignore launch to an active warp and flag it with an assertion.
REQ-025 SHALL make a warp updated or launched at edge N eligible at arbitration no earlier than cycle N+1, so dout_valid for it rises no earlier than edge N+2.
REQ-026 SHALL apply launch and update to different warps in the same cycle independently.
REQ-027 SHALL, on launch and update to the same warp in the same cycle, apply the update and ignore the launch.
REQ-028 SHALL, with no eligible warp, drive dout_valid=0; dout contents are then don't-care.
REQ-029 SHALL, when rdy=0, freeze all registers and ignore launch, update and handshake.

Reset
REQ-030 SHALL, while rst=1 at a clk edge, clear active, pending, pc and split_table_num to 0, set last_grant=NUM_WARPS-1, and drive dout_valid=0, dout=0 and active_mask=0.
REQ-031 SHALL let a mid-operation reset discard an offered-but-unaccepted dout and all pending state; the first post-reset dout_valid=1 requires a new launch.

Structure
REQ-032 SHALL place NUM_WARPS, warp_num_t and pc_update_t in package gelato_types, beside the existing pc_info_t and addr_t.
REQ-033 SHALL implement arbitration in sub-module gelato_rr_arbiter (request vector, last_grant in; grant one-hot, grant index and any out; purely combinational).
REQ-034 SHALL keep the expected RTL size at 150-250 lines in total.

Verification
REQ-035 SHALL cover: reset, launch warp 2 pc=0x100 -> dout_valid=1 two edges later, dout={pc 0x100, warp 2, split 0}.
REQ-036 SHALL cover: launch warps 0-3, dout_ready=1 constantly -> grants 0,1,2,3 on consecutive cycles, then dout_valid=0.
REQ-037 SHALL cover: dout_ready=0 for 5 cycles with warp 1 offered while warp 3 launches -> dout holds warp 1 throughout; warp 3 is granted after warp 1's handshake.
REQ-038 SHALL cover: update warp 1 pc=0x204, exit=0 -> warp 1 re-offered with pc 0x204; next update with exit=1 -> active_mask bit 1 clears and warp 1 is never offered again.
REQ-039 SHALL cover: rdy=0 during a handshake and an update -> no state change; the same stimulus with rdy=1 takes effect.
REQ-040 SHALL cover: rst=1 while dout_valid=1 with warps pending -> next cycle dout_valid=0 and active_mask=0.
